tt_um_serial_sub: RTL and testbench

- LSB-first bit-serial subtractor; computes A − B one bit pair per accepted beat.
- Uses a registered borrow chain and collects the WIDTH-bit difference into a parallel word.
- Counterpart to the team's combinational half-adder tile: it subtracts instead of adds, and it consumes serial streams instead of parallel bits.
- Sits in the standard Tiny Tapeout user-tile wrapper.

---
 rtl/tt_um_serial_sub.sv | 145 ++++++++++++++
 tb/tb_tt_um_serial_sub.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tt_um_serial_sub.sv
// LSB-first bit-serial subtractor (A - B) with a registered borrow chain.
// Each accepted beat yields one difference bit; completed words are presented in parallel on uio_out.
module tt_um_serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               bit_valid_q, bit_valid_d;
    logic               word_done_q, word_done_d;
    logic               word_borrow_q, word_borrow_d;
    logic               seq_err_q, seq_err_d;

    logic               a_bit, b_bit, in_valid, in_first;
    logic               accept, bin, d_bit, bo_bit;
    logic [CNT_W-1:0]   idx, cnt_nxt;
    logic [WIDTH-1:0]   sh_nxt;

    assign a_bit    = ui_in[0];
    assign b_bit    = ui_in[1];
    assign in_valid = ui_in[2];
    assign in_first = ui_in[3];

    // Pins with no function in this tile.
    logic unused_ok;
    assign unused_ok = ^{ena, uio_in, ui_in[7:4]};

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            borrow_q      <= 1'b0;
            shreg_q       <= '0;
            word_q        <= '0;
            diff_q        <= 1'b0;
            bout_q        <= 1'b0;
            bit_valid_q   <= 1'b0;
            word_done_q   <= 1'b0;
            word_borrow_q <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            borrow_q      <= borrow_d;
            shreg_q       <= shreg_d;
            word_q        <= word_d;
            diff_q        <= diff_d;
            bout_q        <= bout_d;
            bit_valid_q   <= bit_valid_d;
            word_done_q   <= word_done_d;
            word_borrow_q <= word_borrow_d;
            seq_err_q     <= seq_err_d;
        end
    end

    // Next-state: a first=1 beat always restarts at bit 0 with no borrow in.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        borrow_d      = borrow_q;
        shreg_d       = shreg_q;
        word_d        = word_q;
        diff_d        = diff_q;
        bout_d        = bout_q;
        bit_valid_d   = 1'b0;
        word_done_d   = 1'b0;
        word_borrow_d = word_borrow_q;
        seq_err_d     = seq_err_q;
        accept        = 1'b0;

        bin     = in_first ? 1'b0 : borrow_q;
        idx     = in_first ? '0 : cnt_q;
        d_bit   = a_bit ^ b_bit ^ bin;
        bo_bit  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
        cnt_nxt = idx + CNT_W'(1);
        sh_nxt  = shreg_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (idx == CNT_W'(i)) begin
                sh_nxt[i] = d_bit;
            end
        end

        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_first) begin
                        accept = 1'b1;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                ST_ACCUM: accept = 1'b1;
                default:  accept = 1'b0;
            endcase
            if (in_first) begin
                seq_err_d = 1'b0;
            end
        end

        if (accept) begin
            diff_d      = d_bit;
            bout_d      = bo_bit;
            bit_valid_d = 1'b1;
            borrow_d    = bo_bit;
            shreg_d     = sh_nxt;
            if (cnt_nxt == CNT_W'(WIDTH)) begin
                word_d        = sh_nxt;
                word_borrow_d = bo_bit;
                word_done_d   = 1'b1;
                cnt_d         = '0;
                state_d       = ST_IDLE;
            end else begin
                cnt_d   = cnt_nxt;
                state_d = ST_ACCUM;
            end
        end
    end

    assign uo_out  = {2'b00, seq_err_q, word_borrow_q, word_done_q, bit_valid_q, bout_q, diff_q};
    assign uio_out = 8'(word_q);
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Randomized self-checking bench for tt_um_serial_sub (WIDTH=8).
// Expected values come from integer arithmetic on whole words, not from bit-level borrow logic.
module tb_tt_um_serial_sub;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests_run;
    int tests_failed;

    // Model of held/sticky outputs.
    logic [7:0] m_word;
    logic       m_wb;
    logic       m_err;
    logic       m_d;
    logic       m_bo;

    tt_um_serial_sub #(.WIDTH(8)) dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given ui_in; outputs are checked 1 time unit after the edge.
    task automatic cyc(input logic [7:0] ui, input logic bv, input logic wd, input string tag);
        ui_in  = ui;
        uio_in = 8'($urandom);
        @(posedge clk);
        #1;
        check({tag, "/uo"}, 32'(uo_out), 32'({2'b00, m_err, m_wb, wd, bv, m_bo, m_d}));
        check({tag, "/uio"}, 32'(uio_out), 32'(m_word));
        check({tag, "/oe"}, 32'(uio_oe), 32'h0000_00FF);
    endtask

    function automatic logic [7:0] mk_ui(input logic a, input logic b, input logic v, input logic f);
        logic [3:0] junk;
        junk = 4'($urandom);
        return {junk, f, v, b, a};
    endfunction

    // Model a single beat of a word using whole-number arithmetic on the low i+1 bits.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input int i, input int n_total,
                        input string tag);
        int mask;
        int diff;
        logic ab;
        logic bb;
        mask = (1 << (i + 1)) - 1;
        diff = (int'(a) - int'(b)) & 255;
        m_d  = 1'((diff >> i) & 1);
        m_bo = ((int'(a) & mask) < (int'(b) & mask)) ? 1'b1 : 1'b0;
        m_err = 1'b0;
        if (i == 7 && n_total == 8) begin
            m_word = 8'(diff);
            m_wb   = (a < b) ? 1'b1 : 1'b0;
        end
        ab = 1'((int'(a) >> i) & 1);
        bb = 1'((int'(b) >> i) & 1);
        cyc(mk_ui(ab, bb, 1'b1, (i == 0) ? 1'b1 : 1'b0), 1'b1,
            (i == 7 && n_total == 8) ? 1'b1 : 1'b0, tag);
    endtask

    task automatic stall(input int n, input string tag);
        for (int s = 0; s < n; s++) begin
            cyc(mk_ui(1'($urandom), 1'($urandom), 1'b0, 1'($urandom)), 1'b0, 1'b0, tag);
        end
    endtask

    // Send n beats of A-B (n=8 completes the word), stalling stall_len cycles after beat stall_at.
    task automatic send_word(input logic [7:0] a, input logic [7:0] b, input int n,
                             input int stall_at, input int stall_len, input string tag);
        for (int i = 0; i < n; i++) begin
            beat(a, b, i, n, tag);
            if (i == stall_at) stall(stall_len, {tag, "/stall"});
        end
    endtask

    task automatic stray_beat(input string tag);
        m_err = 1'b1;
        cyc(mk_ui(1'($urandom), 1'($urandom), 1'b1, 1'b0), 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(input int n, input string tag);
        rst_n  = 1'b0;
        m_word = '0;
        m_wb   = 1'b0;
        m_err  = 1'b0;
        m_d    = 1'b0;
        m_bo   = 1'b0;
        for (int k = 0; k < n; k++) begin
            cyc(mk_ui(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)), 1'b0, 1'b0, tag);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         sat;
        tests_run    = 0;
        tests_failed = 0;
        ena    = 1'b1;
        rst_n  = 1'b0;
        ui_in  = '0;
        uio_in = '0;
        @(posedge clk);
        #1;
        do_reset(2, "reset");

        send_word(8'h05, 8'h03, 8, -1, 0, "w05_03");
        send_word(8'h03, 8'h05, 8, -1, 0, "w03_05");
        send_word(8'h00, 8'h00, 8, -1, 0, "w00_00");
        send_word(8'hFF, 8'h01, 8, -1, 0, "wFF_01");
        stall(2, "idle");

        send_word(8'h05, 8'h03, 8, 3, 3, "stall3");

        send_word(8'hA7, 8'h5C, 4, -1, 0, "abort");
        send_word(8'h10, 8'h01, 8, -1, 0, "w10_01");

        do_reset(1, "rst2");
        stray_beat("seqerr");
        stall(3, "seqerr_hold");
        send_word(8'h05, 8'h03, 8, -1, 0, "seqerr_clear");

        send_word(8'h3C, 8'h99, 6, -1, 0, "midword");
        do_reset(1, "rst_mid");
        send_word(8'h81, 8'h7E, 8, -1, 0, "after_rst");

        for (int w = 0; w < 60; w++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            sat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            if ($urandom_range(0, 7) == 0) begin
                stall(int'($urandom_range(0, 2)), "rnd_gap");
                stray_beat("rnd_stray");
            end
            if ($urandom_range(0, 9) == 0) begin
                send_word(8'($urandom), 8'($urandom), int'($urandom_range(1, 7)), -1, 0, "rnd_abort");
            end
            send_word(ra, rb, 8, sat, int'($urandom_range(1, 3)), "rnd");
            if ($urandom_range(0, 3) == 0) stall(int'($urandom_range(1, 2)), "rnd_idle");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
